// File: rtl/axi_rd_responder_pkg.sv
// Shared AXI read-channel types, response codes and data-width constants
// for the read responder and its address sequencer.
package axi_rd_responder_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;

  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [AXI_ID_W-1:0]   axi_id_t;
  typedef logic [7:0]            axi_len_t;
  typedef logic [2:0]            axi_size_t;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } axi_burst_t;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  localparam int DATA_BYTES = $bits(axi_data_t) / 8;
  localparam int ADDR_LSB   = $clog2(DATA_BYTES);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } rd_state_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input axi_len_t len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI read address (A) and read data (R) channel bundle; one instance can
// feed both channel ports of a completer through per-channel modports.
interface axi_rd_responder_if;
  import axi_rd_responder_pkg::*;

  logic       avalid;
  logic       aready;
  axi_id_t    aid;
  axi_addr_t  aaddr;
  axi_len_t   alen;
  axi_size_t  asize;
  logic [1:0] aburst;

  logic       rvalid;
  logic       rready;
  axi_id_t    rid;
  axi_data_t  rdata;
  axi_resp_t  rresp;
  logic       rlast;

  modport a_src (output avalid, aid, aaddr, alen, asize, aburst, input aready);
  modport a_dst (input avalid, aid, aaddr, alen, asize, aburst, output aready);
  modport r_src (output rvalid, rid, rdata, rresp, rlast, input rready);
  modport r_dst (input rvalid, rid, rdata, rresp, rlast, output rready);

  modport master (output avalid, aid, aaddr, alen, asize, aburst, rready,
                  input aready, rvalid, rid, rdata, rresp, rlast);
  modport slave  (input avalid, aid, aaddr, alen, asize, aburst, rready,
                  output aready, rvalid, rid, rdata, rresp, rlast);
endinterface

// File: rtl/axi_next_addr.sv
// Combinational AXI burst address sequencer: given the current beat address
// and burst attributes, produce the address of the following beat.
module axi_next_addr
  import axi_rd_responder_pkg::*;
(
  input  axi_addr_t  addr_i,
  input  axi_size_t  size_i,
  input  axi_len_t   len_i,
  input  logic [1:0] burst_i,
  output axi_addr_t  next_o
);

  axi_addr_t db;
  axi_addr_t wrap_mask;

  // The wrap boundary is a power of two for every legal WRAP length, so the
  // modulo reduces to a mask; illegal lengths are answered with SLVERR.
  always_comb begin
    db        = axi_addr_t'(1) << size_i;
    wrap_mask = ((axi_addr_t'(len_i) + axi_addr_t'(1)) << size_i) - axi_addr_t'(1);
    next_o    = addr_i;
    case (burst_i)
      FIXED:   next_o = addr_i;
      INCR:    next_o = (addr_i & ~(db - axi_addr_t'(1))) + db;
      WRAP:    next_o = (addr_i & ~wrap_mask) + ((addr_i + db) & wrap_mask);
      default: next_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI read completer backed by a word-addressed memory with a sideband
// preload port; serves one burst at a time with registered outputs.
module axi_rd_responder
  import axi_rd_responder_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_rd_responder_if.a_dst            ar_if,
  axi_rd_responder_if.r_src            r_if,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] wr_idx,
  input  axi_data_t                    wr_data
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  axi_data_t mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  rd_state_t  state_q, state_d;
  logic       aready_q, aready_d;
  logic       rvalid_q, rvalid_d;
  logic       rlast_q, rlast_d;
  axi_id_t    rid_q, rid_d;
  axi_data_t  rdata_q, rdata_d;
  axi_resp_t  rresp_q, rresp_d;
  axi_len_t   beat_q, beat_d;

  axi_id_t    id_q, id_d;
  axi_len_t   len_q, len_d;
  axi_size_t  size_q, size_d;
  logic [1:0] burst_q, burst_d;
  axi_addr_t  addr_q, addr_d;

  logic       in_idle;
  axi_addr_t  sel_addr;
  axi_size_t  sel_size;
  axi_len_t   sel_len;
  logic [1:0] sel_burst;
  axi_id_t    sel_id;
  axi_addr_t  next_addr;
  axi_addr_t  word;
  logic       decerr;
  logic       slverr;
  axi_data_t  beat_data;
  axi_resp_t  beat_resp;
  logic       load;

  // Beat 0 is built from the live AR fields; later beats from the latched context.
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    sel_addr  = in_idle ? ar_if.aaddr  : addr_q;
    sel_size  = in_idle ? ar_if.asize  : size_q;
    sel_len   = in_idle ? ar_if.alen   : len_q;
    sel_burst = in_idle ? ar_if.aburst : burst_q;
    sel_id    = in_idle ? ar_if.aid    : id_q;
  end

  axi_next_addr u_next_addr (
    .addr_i  (sel_addr),
    .size_i  (sel_size),
    .len_i   (sel_len),
    .burst_i (sel_burst),
    .next_o  (next_addr)
  );

  // Range check on the full-width word index before it is cut to IDX_W bits.
  always_comb begin
    word      = sel_addr >> ADDR_LSB;
    decerr    = (word >= axi_addr_t'(MEM_DEPTH));
    slverr    = (sel_burst == 2'd3) ||
                (sel_size > axi_size_t'(ADDR_LSB)) ||
                ((sel_burst == WRAP) && !wrap_len_ok(sel_len));
    beat_data = '0;
    beat_resp = RESP_OKAY;
    if (decerr) begin
      beat_resp = RESP_DECERR;
    end else if (slverr) begin
      beat_resp = RESP_SLVERR;
    end else begin
      beat_data = mem[word[IDX_W-1:0]];
    end
  end

  always_comb begin
    state_d  = state_q;
    aready_d = aready_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    beat_d   = beat_q;
    id_d     = id_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    addr_d   = addr_q;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        aready_d = 1'b1;
        if (ar_if.avalid && aready_q) begin
          aready_d = 1'b0;
          state_d  = ST_BURST;
          load     = 1'b1;
          beat_d   = '0;
          rlast_d  = (ar_if.alen == '0);
          id_d     = ar_if.aid;
          len_d    = ar_if.alen;
          size_d   = ar_if.asize;
          burst_d  = ar_if.aburst;
        end
      end
      ST_BURST: begin
        if (rvalid_q && r_if.rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            aready_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            load    = 1'b1;
            beat_d  = beat_q + 8'd1;
            rlast_d = ((beat_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      rvalid_d = 1'b1;
      rid_d    = sel_id;
      rdata_d  = beat_data;
      rresp_d  = beat_resp;
      addr_d   = next_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      aready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      aready_q <= aready_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      beat_q   <= beat_d;
    end
  end

  // Burst context only matters while rvalid is up, so it carries no reset.
  always_ff @(posedge clk) begin
    id_q    <= id_d;
    len_q   <= len_d;
    size_q  <= size_d;
    burst_q <= burst_d;
    addr_q  <= addr_d;
  end

  assign ar_if.aready = aready_q;
  assign r_if.rvalid  = rvalid_q;
  assign r_if.rlast   = rlast_q;
  assign r_if.rid     = rid_q;
  assign r_if.rdata   = rdata_q;
  assign r_if.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: directed scenarios plus randomized bursts
// checked against an address/response model built from the burst rules.
module tb_axi_rd_responder;
  import axi_rd_responder_pkg::*;

  localparam int MEM_DEPTH = 1024;
  localparam int DB        = DATA_BYTES;

  logic            clk;
  logic            rst;
  logic            wr_en;
  logic [9:0]      wr_idx;
  axi_data_t       wr_data;

  axi_rd_responder_if bus ();

  axi_rd_responder #(.MEM_DEPTH(MEM_DEPTH), .INIT_FILE("")) dut (
    .clk     (clk),
    .rst     (rst),
    .ar_if   (bus),
    .r_if    (bus),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  axi_data_t mem_m [MEM_DEPTH];

  axi_id_t   q_id[$];
  axi_data_t q_data[$];
  axi_resp_t q_resp[$];
  logic      q_last[$];
  int        q_cyc[$];
  logic      first_rv;
  logic      aready_hi;
  logic      timed_out;
  logic      hs_ok;
  int        hs_cyc;

  task automatic ar_issue(input axi_id_t id, input axi_addr_t addr, input axi_len_t len,
                          input axi_size_t size, input logic [1:0] burst);
    logic was;
    bus.avalid = 1'b1;
    bus.aid    = id;
    bus.aaddr  = addr;
    bus.alen   = len;
    bus.asize  = size;
    bus.aburst = burst;
    hs_ok = 1'b0;
    for (int k = 0; k < 20 && !hs_ok; k++) begin
      was = bus.aready;
      @(posedge clk); #1;
      if (was) hs_ok = 1'b1;
    end
    bus.avalid = 1'b0;
    hs_cyc = cyc;
  endtask

  task automatic collect(input bit rand_rdy);
    logic done;
    q_id.delete(); q_data.delete(); q_resp.delete(); q_last.delete(); q_cyc.delete();
    first_rv  = bus.rvalid;
    aready_hi = 1'b0;
    timed_out = 1'b1;
    done      = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      bus.rready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.aready) aready_hi = 1'b1;
      if (bus.rvalid && bus.rready) begin
        q_id.push_back(bus.rid);
        q_data.push_back(bus.rdata);
        q_resp.push_back(bus.rresp);
        q_last.push_back(bus.rlast);
        q_cyc.push_back(cyc);
        if (bus.rlast) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (done) timed_out = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic sideband_write(input int idx, input axi_data_t val);
    wr_en   = 1'b1;
    wr_idx  = 10'(idx);
    wr_data = val;
    mem_m[idx] = val;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (bus.aready !== 1'b0) begin n_fail++; $display("FAIL reset_aready got=%0b exp=0", bus.aready); end
    n_tests++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%0b exp=0", bus.rvalid); end
    n_tests++; if (bus.rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rlast got=%0b exp=0", bus.rlast); end
    n_tests++; if (bus.rid !== '0) begin n_fail++; $display("FAIL reset_rid got=%0h exp=0", bus.rid); end
    n_tests++; if (bus.rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%0h exp=0", bus.rdata); end
    n_tests++; if (bus.rresp !== RESP_OKAY) begin n_fail++; $display("FAIL reset_rresp got=%0h exp=0", bus.rresp); end
    @(posedge clk); #4;
    rst = 1'b0;
    #1;
    n_tests++; if (bus.aready !== 1'b0) begin n_fail++; $display("FAIL release_aready_early got=%0b exp=0", bus.aready); end
    @(posedge clk); #1;
    n_tests++; if (bus.aready !== 1'b1) begin n_fail++; $display("FAIL release_aready got=%0b exp=1", bus.aready); end
  endtask

  task automatic preload;
    for (int i = 0; i < MEM_DEPTH; i++) sideband_write(i, axi_data_t'(i));
  endtask

  task automatic test_incr;
    ar_issue(4'd5, axi_addr_t'(4 * DB), 8'd3, 3'd2, INCR);
    collect(1'b0);
    n_tests++; if (hs_ok !== 1'b1 || timed_out !== 1'b0) begin n_fail++; $display("FAIL incr_handshake hs=%0b timeout=%0b exp hs=1 timeout=0", hs_ok, timed_out); end
    n_tests++; if (first_rv !== 1'b1) begin n_fail++; $display("FAIL incr_latency rvalid_after_ar=%0b exp=1", first_rv); end
    n_tests++; if (q_data.size() != 4) begin n_fail++; $display("FAIL incr_beats got=%0d exp=4", q_data.size()); end
    for (int i = 0; i < q_data.size(); i++) begin
      n_tests++; if (q_data[i] !== axi_data_t'(4 + i) || q_id[i] !== 4'd5 || q_resp[i] !== RESP_OKAY || q_last[i] !== (i == 3)) begin
        n_fail++; $display("FAIL incr_beat%0d data=%0h id=%0h resp=%0h last=%0b exp data=%0h id=5 resp=0 last=%0b", i, q_data[i], q_id[i], q_resp[i], q_last[i], 4 + i, i == 3);
      end
      n_tests++; if (q_cyc[i] != hs_cyc + i) begin n_fail++; $display("FAIL incr_cycle%0d got=%0d exp=%0d", i, q_cyc[i], hs_cyc + i); end
    end
    n_tests++; if (bus.rvalid !== 1'b0 || bus.aready !== 1'b1) begin n_fail++; $display("FAIL incr_end rvalid=%0b aready=%0b exp rvalid=0 aready=1", bus.rvalid, bus.aready); end
  endtask

  task automatic test_wrap_fixed;
    int exp_w [4] = '{6, 7, 4, 5};
    ar_issue(4'd2, axi_addr_t'(6 * DB), 8'd3, 3'd2, WRAP);
    collect(1'b0);
    n_tests++; if (q_data.size() != 4) begin n_fail++; $display("FAIL wrap_beats got=%0d exp=4", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      n_tests++; if (q_data[i] !== axi_data_t'(exp_w[i]) || q_resp[i] !== RESP_OKAY || q_last[i] !== (i == 3)) begin
        n_fail++; $display("FAIL wrap_beat%0d data=%0h resp=%0h last=%0b exp data=%0h resp=0 last=%0b", i, q_data[i], q_resp[i], q_last[i], exp_w[i], i == 3);
      end
    end
    ar_issue(4'd3, axi_addr_t'(3 * DB), 8'd2, 3'd2, FIXED);
    collect(1'b0);
    n_tests++; if (q_data.size() != 3) begin n_fail++; $display("FAIL fixed_beats got=%0d exp=3", q_data.size()); end
    for (int i = 0; i < q_data.size(); i++) begin
      n_tests++; if (q_data[i] !== 32'd3 || q_id[i] !== 4'd3 || q_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL fixed_beat%0d data=%0h id=%0h last=%0b exp data=3 id=3 last=%0b", i, q_data[i], q_id[i], q_last[i], i == 2);
      end
    end
  endtask

  task automatic test_errors;
    logic [1:0] t_burst [4] = '{2'd3, 2'd1, 2'd2, 2'd1};
    axi_addr_t  t_addr  [4] = '{32'd0, 32'(MEM_DEPTH * DB), 32'd0, 32'd0};
    axi_len_t   t_len   [4] = '{8'd3, 8'd0, 8'd2, 8'd0};
    axi_size_t  t_size  [4] = '{3'd2, 3'd2, 3'd2, 3'd3};
    axi_resp_t  t_resp  [4] = '{RESP_SLVERR, RESP_DECERR, RESP_SLVERR, RESP_SLVERR};
    for (int t = 0; t < 4; t++) begin
      ar_issue(axi_id_t'(8 + t), t_addr[t], t_len[t], t_size[t], t_burst[t]);
      collect(1'b0);
      n_tests++; if (q_data.size() != int'(t_len[t]) + 1) begin n_fail++; $display("FAIL err%0d_beats got=%0d exp=%0d", t, q_data.size(), int'(t_len[t]) + 1); end
      for (int i = 0; i < q_data.size(); i++) begin
        n_tests++; if (q_resp[i] !== t_resp[t] || q_data[i] !== '0 || q_id[i] !== axi_id_t'(8 + t) || q_last[i] !== (i == int'(t_len[t]))) begin
          n_fail++; $display("FAIL err%0d_beat%0d resp=%0h data=%0h id=%0h last=%0b exp resp=%0h data=0 id=%0h last=%0b",
                             t, i, q_resp[i], q_data[i], q_id[i], q_last[i], t_resp[t], 8 + t, i == int'(t_len[t]));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    bus.rready = 1'b0;
    ar_issue(4'd1, axi_addr_t'(10 * DB), 8'd1, 3'd2, INCR);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'd10 || bus.rlast !== 1'b0 || bus.aready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d rvalid=%0b rdata=%0h rlast=%0b aready=%0b exp 1/a/0/0", k, bus.rvalid, bus.rdata, bus.rlast, bus.aready);
      end
      @(posedge clk); #1;
    end
    bus.rready = 1'b1;
    n_tests++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'd10) begin n_fail++; $display("FAIL bp_beat0 rvalid=%0b rdata=%0h exp 1/a", bus.rvalid, bus.rdata); end
    @(posedge clk); #1;
    n_tests++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'd11 || bus.rlast !== 1'b1 || bus.aready !== 1'b0) begin
      n_fail++; $display("FAIL bp_beat1 rvalid=%0b rdata=%0h rlast=%0b aready=%0b exp 1/b/1/0", bus.rvalid, bus.rdata, bus.rlast, bus.aready);
    end
    @(posedge clk); #1;
    bus.rready = 1'b0;
    n_tests++; if (bus.rvalid !== 1'b0 || bus.aready !== 1'b1) begin n_fail++; $display("FAIL bp_end rvalid=%0b aready=%0b exp 0/1", bus.rvalid, bus.aready); end
  endtask

  task automatic test_same_edge_write;
    n_tests++; if (bus.aready !== 1'b1) begin n_fail++; $display("FAIL sew_idle aready=%0b exp=1", bus.aready); end
    bus.avalid = 1'b1; bus.aid = 4'd4; bus.aaddr = axi_addr_t'(8 * DB);
    bus.alen = 8'd0; bus.asize = 3'd2; bus.aburst = INCR; bus.rready = 1'b1;
    wr_en = 1'b1; wr_idx = 10'd8; wr_data = 32'hAA;
    @(posedge clk); #1;
    bus.avalid = 1'b0; wr_en = 1'b0;
    mem_m[8] = 32'hAA;
    n_tests++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'd8 || bus.rlast !== 1'b1) begin
      n_fail++; $display("FAIL sew_old_data rvalid=%0b rdata=%0h rlast=%0b exp 1/8/1", bus.rvalid, bus.rdata, bus.rlast);
    end
    @(posedge clk); #1;
    bus.rready = 1'b0;
    ar_issue(4'd4, axi_addr_t'(8 * DB), 8'd0, 3'd2, INCR);
    collect(1'b0);
    n_tests++; if (q_data.size() != 1 || q_data[0] !== 32'hAA) begin
      n_fail++; $display("FAIL sew_reread beats=%0d data=%0h exp 1 beat data=aa", q_data.size(), q_data.size() > 0 ? q_data[0] : 32'hX);
    end
  endtask

  task automatic test_reset_mid_burst;
    ar_issue(4'd3, axi_addr_t'(0), 8'd7, 3'd2, INCR);
    bus.rready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'd2) begin n_fail++; $display("FAIL rmb_beat2 rvalid=%0b rdata=%0h exp 1/2", bus.rvalid, bus.rdata); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.rvalid !== 1'b0 || bus.aready !== 1'b0) begin n_fail++; $display("FAIL rmb_async rvalid=%0b aready=%0b exp 0/0", bus.rvalid, bus.aready); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rready = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (bus.aready !== 1'b1 || bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rmb_release aready=%0b rvalid=%0b exp 1/0", bus.aready, bus.rvalid); end
    ar_issue(4'd6, axi_addr_t'(5 * DB), 8'd0, 3'd2, INCR);
    collect(1'b0);
    n_tests++; if (q_data.size() != 1 || q_data[0] !== 32'd5 || q_id[0] !== 4'd6 || q_last[0] !== 1'b1 || q_resp[0] !== RESP_OKAY) begin
      n_fail++; $display("FAIL rmb_newread beats=%0d data=%0h exp 1 beat data=5 id=6 last=1 okay", q_data.size(), q_data.size() > 0 ? q_data[0] : 32'hX);
    end
  endtask

  task automatic test_random;
    axi_id_t    id;
    logic [1:0] burst;
    axi_size_t  size;
    axi_len_t   len;
    axi_addr_t  addr, db, bnd, base, a, wd;
    axi_data_t  e_data;
    axi_resp_t  e_resp;
    int         wlens [4] = '{1, 3, 7, 15};
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) sideband_write($urandom_range(0, MEM_DEPTH - 1), $urandom);
      id    = axi_id_t'($urandom);
      burst = 2'($urandom_range(0, 2));
      size  = 3'($urandom_range(0, 2));
      len   = (burst == WRAP) ? axi_len_t'(wlens[$urandom_range(0, 3)]) : axi_len_t'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFC0 + axi_addr_t'($urandom_range(0, 63));
      else addr = axi_addr_t'($urandom_range(0, MEM_DEPTH * DB + 127));
      ar_issue(id, addr, len, size, burst);
      collect(1'b1);
      n_tests++; if (hs_ok !== 1'b1 || timed_out !== 1'b0 || q_data.size() != int'(len) + 1 || aready_hi !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_shape hs=%0b timeout=%0b beats=%0d aready_seen=%0b exp 1/0/%0d/0", t, hs_ok, timed_out, q_data.size(), aready_hi, int'(len) + 1);
      end
      db   = axi_addr_t'(1) << size;
      bnd  = (axi_addr_t'(len) + 1) * db;
      base = addr - (addr % bnd);
      for (int n = 0; n < q_data.size(); n++) begin
        case (burst)
          2'd1:    a = (n == 0) ? addr : (addr - (addr % db)) + axi_addr_t'(n) * db;
          2'd2:    a = base + (((addr - base) + axi_addr_t'(n) * db) % bnd);
          default: a = addr;
        endcase
        wd = a / axi_addr_t'(DB);
        if (wd >= axi_addr_t'(MEM_DEPTH)) begin e_resp = RESP_DECERR; e_data = '0; end
        else begin e_resp = RESP_OKAY; e_data = mem_m[int'(wd)]; end
        n_tests++; if (q_data[n] !== e_data || q_resp[n] !== e_resp || q_id[n] !== id || q_last[n] !== (n == int'(len))) begin
          n_fail++; $display("FAIL rand%0d_beat%0d addr=%0h data=%0h resp=%0h id=%0h last=%0b exp data=%0h resp=%0h id=%0h last=%0b",
                             t, n, a, q_data[n], q_resp[n], q_id[n], q_last[n], e_data, e_resp, id, n == int'(len));
        end
      end
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    bus.avalid = 1'b0; bus.aid = '0; bus.aaddr = '0; bus.alen = '0;
    bus.asize = '0; bus.aburst = '0; bus.rready = 1'b0;
    timed_out = 1'b0; hs_ok = 1'b0; first_rv = 1'b0; aready_hi = 1'b0; hs_cyc = 0;
    test_reset();
    preload();
    test_incr();
    test_wrap_fixed();
    test_errors();
    test_backpressure();
    test_same_edge_write();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
